io_ctrl_gen: RTL and testbench

Parametrised, single-clock successor of the MCU I/O control block. It receives the two-wire serial register stream (SCK/SDA), decodes it into the acquisition control registers, and drives the 16-bit MCU data bus with sample data, a status word, or per-channel measurement readback. New relative to the previous generation:
- synchronous oversampled front end
- N-channel readback
- address auto-increment
- framing-error detection
- per-write strobe

---
 rtl/io_ctrl_gen_if.sv | 31 +++
 rtl/io_ctrl_gen.sv | 249 ++++++++++++++++++++++++
 tb/tb_io_ctrl_gen.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_ctrl_gen_if.sv
// ---------------------------------------------------------------------------
// io_ctrl_gen_if
//
// Purpose : MCU-side pin group of the I/O control block. It carries the
//           two-wire serial register stream and the parallel bus controls.
//           The 16-bit data bus itself stays a plain inout on io_ctrl_gen so
//           that its tri-state driver is resolved at the module boundary.
//
// Signals : SCK, SDA  serial clock / data, asynchronous to Clk
//           CE        bus select, active high
//           nRD       read strobe, active low
//           H_L       serial: 1 = address byte, 0 = data byte
//                     bus   : 1 = FIFO sample data on the bus
//           C_D       bus (H_L = 0): 1 = measurement readback, 0 = status
//
// Modports: master  - MCU / testbench side, drives every signal
//           slave   - io_ctrl_gen side, samples every signal
// ---------------------------------------------------------------------------
interface io_ctrl_gen_if;
   logic SCK;
   logic SDA;
   logic CE;
   logic nRD;
   logic H_L;
   logic C_D;

   modport master (output SCK, output SDA, output CE, output nRD,
                   output H_L, output C_D);
   modport slave  (input SCK, input SDA, input CE, input nRD,
                   input H_L, input C_D);
endinterface

// File: rtl/io_ctrl_gen.sv
// ---------------------------------------------------------------------------
// io_ctrl_gen
//
// Purpose : Single-clock MCU I/O control block. Oversamples the two-wire
//           serial register stream (SCK/SDA), decodes it into the
//           acquisition control registers, and drives the 16-bit MCU data
//           bus with FIFO sample data, a status word or per-channel
//           measurement readback.
//
// Parameters:
//   NCH        number of measurement channels (1..64)
//   DEPTH_W    Depth register width (9..16)
//   PERCNT_W   PerCnt register width (9..16)
//   DELAY_W    Delay register width (25..32)
//   PRE_PERCNT PerCnt value preset by a Trigg_Mode write
//
// Ports:
//   Clk, nRst          clock (rising edge) / asynchronous active-low reset
//   bus                serial and bus controls (io_ctrl_gen_if.slave)
//   Dout[17:0]         FIFO sample data
//   Start, Empty,
//   Full, Ready        acquisition status inputs
//   Meas[NCH*48-1:0]   item j (0 Edge, 1 TL, 2 TH) of channel k at
//                      bits [(3k+j)*16 +: 16]
//   Trigg_Mode, Vthreshold, CtrlReg (8), Tthreshold (16),
//   Depth, PerCnt, Delay                 control register outputs
//   nPD                ADC power-down control, follows CtrlReg[0]
//   WrStb, WrAddr      one-cycle pulse and address of each mapped write
//   DB[15:0]           MCU data bus, driven only while CE=1 and nRD=0
//
// Serial register map (RegAddr):
//   00 Trigg_Mode (also presets Depth/PerCnt/Delay)   01 Vthreshold
//   02/03 Tthreshold lo/hi   04 CtrlReg   05 Select   06/07 Depth lo/hi
//   08/09 PerCnt lo/hi       0A..0D Delay bytes 0..3  0E SerErr clear
//   0F..FF unmapped: ignored, but RegAddr still advances.
//
// Serial handshake: a bit is shifted on every synchronised SCK rise; a frame
// is committed by an SDA rise while SCK is low. A commit with exactly 8 bits
// shifted writes the byte (address or data depending on H_L); any other bit
// count discards the frame and latches SerErr.
// ---------------------------------------------------------------------------
module io_ctrl_gen #(
   parameter int NCH        = 4,
   parameter int DEPTH_W    = 12,
   parameter int PERCNT_W   = 12,
   parameter int DELAY_W    = 32,
   parameter int PRE_PERCNT = 150
) (
   input  logic                  Clk,
   input  logic                  nRst,
   io_ctrl_gen_if.slave          bus,
   input  logic [17:0]           Dout,
   input  logic                  Start,
   input  logic                  Empty,
   input  logic                  Full,
   input  logic                  Ready,
   input  logic [NCH*48-1:0]     Meas,
   output logic [7:0]            Trigg_Mode,
   output logic [7:0]            Vthreshold,
   output logic [7:0]            CtrlReg,
   output logic [15:0]           Tthreshold,
   output logic [DEPTH_W-1:0]    Depth,
   output logic [PERCNT_W-1:0]   PerCnt,
   output logic [DELAY_W-1:0]    Delay,
   output logic                  nPD,
   output logic                  WrStb,
   output logic [7:0]            WrAddr,
   inout  wire  [15:0]           DB
);

   // ------------------------------------------------------------------
   // Input synchronisers and edge detection
   // ------------------------------------------------------------------
   // Index [1] of each chain is the synchronised copy.
   logic [1:0] sck_sync;
   logic [1:0] sda_sync;
   logic [1:0] nrd_sync;
   logic       sck_q;
   logic       sda_q;

   // Edge events are registered, which gives the detect stage of the
   // pipeline: pin edge -> 2 sync -> detect -> register write.
   logic       shift_evt;
   logic       shift_bit;
   logic       commit_evt;

   // The SDA chain resets to 1 (line idle high). A line held high through
   // reset therefore does not look like a commit rise once reset releases.
   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         sck_sync   <= 2'b00;
         sda_sync   <= 2'b11;
         nrd_sync   <= 2'b11;
         sck_q      <= 1'b0;
         sda_q      <= 1'b1;
         shift_evt  <= 1'b0;
         shift_bit  <= 1'b0;
         commit_evt <= 1'b0;
      end else begin
         sck_sync   <= {sck_sync[0], bus.SCK};
         sda_sync   <= {sda_sync[0], bus.SDA};
         nrd_sync   <= {nrd_sync[0], bus.nRD};
         sck_q      <= sck_sync[1];
         sda_q      <= sda_sync[1];
         shift_evt  <= sck_sync[1] & ~sck_q;
         // SDA value seen in the same cycle as the SCK rise.
         shift_bit  <= sda_sync[1];
         // A commit needs SCK low, so it can never coincide with a shift.
         commit_evt <= sda_sync[1] & ~sda_q & ~sck_sync[1];
      end
   end

   // ------------------------------------------------------------------
   // Frame assembly and register file
   // ------------------------------------------------------------------
   logic [7:0] shift_reg;
   logic [3:0] bit_cnt;
   logic [7:0] reg_addr;
   logic [7:0] select;
   logic       ser_err;
   logic       addr_mapped;

   assign addr_mapped = (reg_addr <= 8'h0E);

   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         shift_reg  <= 8'h00;
         bit_cnt    <= 4'd0;
         reg_addr   <= 8'h00;
         select     <= 8'h00;
         ser_err    <= 1'b0;
         Trigg_Mode <= 8'h00;
         Vthreshold <= 8'h00;
         CtrlReg    <= 8'h00;
         Tthreshold <= 16'h0000;
         Depth      <= '1;
         PerCnt     <= PERCNT_W'(PRE_PERCNT);
         Delay      <= DELAY_W'(1);
         WrStb      <= 1'b0;
         WrAddr     <= 8'h00;
      end else begin
         WrStb <= 1'b0;

         if (shift_evt) begin
            shift_reg <= {shift_reg[6:0], shift_bit};
            // Saturate so that long frames can never alias back to 8 bits.
            if (bit_cnt != 4'd15) begin
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else if (commit_evt) begin
            bit_cnt <= 4'd0;
            if (bit_cnt != 4'd8) begin
               ser_err <= 1'b1;
            end else if (bus.H_L) begin
               reg_addr <= shift_reg;
            end else begin
               reg_addr <= reg_addr + 8'd1;
               if (addr_mapped) begin
                  WrStb  <= 1'b1;
                  WrAddr <= reg_addr;
               end
               // Bits above a register's width are dropped on the hi bytes.
               case (reg_addr)
                  8'h00: begin
                     Trigg_Mode <= shift_reg;
                     Depth      <= '1;
                     PerCnt     <= PERCNT_W'(PRE_PERCNT);
                     Delay      <= DELAY_W'(1);
                  end
                  8'h01: Vthreshold                  <= shift_reg;
                  8'h02: Tthreshold[7:0]             <= shift_reg;
                  8'h03: Tthreshold[15:8]            <= shift_reg;
                  8'h04: CtrlReg                     <= shift_reg;
                  8'h05: select                      <= shift_reg;
                  8'h06: Depth[7:0]                  <= shift_reg;
                  8'h07: Depth[DEPTH_W-1:8]          <= shift_reg[DEPTH_W-9:0];
                  8'h08: PerCnt[7:0]                 <= shift_reg;
                  8'h09: PerCnt[PERCNT_W-1:8]        <= shift_reg[PERCNT_W-9:0];
                  8'h0A: Delay[7:0]                  <= shift_reg;
                  8'h0B: Delay[15:8]                 <= shift_reg;
                  8'h0C: Delay[23:16]                <= shift_reg;
                  8'h0D: Delay[DELAY_W-1:24]         <= shift_reg[DELAY_W-25:0];
                  8'h0E: ser_err                     <= 1'b0;
                  default: ;
               endcase
            end
         end
      end
   end

   assign nPD = CtrlReg[0];

   // ------------------------------------------------------------------
   // Measurement readback
   // ------------------------------------------------------------------
   logic [5:0]  sel_chan;
   logic [1:0]  sel_item;
   logic [15:0] meas_sel;
   logic [15:0] data;

   assign sel_chan = select[7:2];
   assign sel_item = select[1:0];

   // Item 3 and channels beyond NCH match nothing and read as zero.
   always_comb begin
      meas_sel = 16'h0000;
      for (int k = 0; k < NCH; k++) begin
         for (int j = 0; j < 3; j++) begin
            if (sel_chan == 6'(k) && sel_item == 2'(j)) begin
               meas_sel = Meas[(3*k+j)*16 +: 16];
            end
         end
      end
   end

   // Data tracks the selection while no read is in progress and freezes for
   // the duration of a read, so the MCU sees one consistent word.
   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         data <= 16'h0000;
      end else if (nrd_sync[1]) begin
         data <= meas_sel;
      end
   end

   // ------------------------------------------------------------------
   // MCU data bus
   // ------------------------------------------------------------------
   logic [15:0] status;
   logic [15:0] db_val;
   logic        db_oe;

   assign status = {9'b0, ser_err, Start, Empty, Full, Ready, Dout[17:16]};

   always_comb begin
      db_val = status;
      if (bus.H_L) begin
         db_val = Dout[15:0];
      end else if (bus.C_D) begin
         db_val = data;
      end
   end

   // Output enable comes straight from the raw pins so the bus is released
   // as soon as the MCU deasserts CE or nRD.
   assign db_oe = bus.CE & ~bus.nRD;
   assign DB    = db_oe ? db_val : {16{1'bz}};

endmodule

// File: tb/tb_io_ctrl_gen.sv
// ---------------------------------------------------------------------------
// tb_io_ctrl_gen
//
// Directed bench for io_ctrl_gen (NCH=4, DEPTH_W=12, PERCNT_W=12,
// DELAY_W=32, PRE_PERCNT=150). Serial frames are driven MSB first; every
// mapped data write pushes its address into exp_q and a monitor pops one
// entry per WrStb pulse. DB has a pull-up, so a released bus reads 0xFFFF.
// ---------------------------------------------------------------------------
module tb_io_ctrl_gen;

   localparam int NCH        = 4;
   localparam int DEPTH_W    = 12;
   localparam int PERCNT_W   = 12;
   localparam int DELAY_W    = 32;
   localparam int PRE_PERCNT = 150;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT hookup ----------------
   io_ctrl_gen_if bus ();

   logic [17:0]          dout;
   logic                 start;
   logic                 empty;
   logic                 full;
   logic                 ready;
   logic [NCH*48-1:0]    meas;
   logic [7:0]           trigg_mode;
   logic [7:0]           vthreshold;
   logic [7:0]           ctrl_reg;
   logic [15:0]          tthreshold;
   logic [DEPTH_W-1:0]   depth;
   logic [PERCNT_W-1:0]  per_cnt;
   logic [DELAY_W-1:0]   delay;
   logic                 npd;
   logic                 wr_stb;
   logic [7:0]           wr_addr;
   wire  [15:0]          db;

   pullup pu_db (db);

   io_ctrl_gen #(
      .NCH        (NCH),
      .DEPTH_W    (DEPTH_W),
      .PERCNT_W   (PERCNT_W),
      .DELAY_W    (DELAY_W),
      .PRE_PERCNT (PRE_PERCNT)
   ) dut (
      .Clk        (clk),
      .nRst       (rst_n),
      .bus        (bus),
      .Dout       (dout),
      .Start      (start),
      .Empty      (empty),
      .Full       (full),
      .Ready      (ready),
      .Meas       (meas),
      .Trigg_Mode (trigg_mode),
      .Vthreshold (vthreshold),
      .CtrlReg    (ctrl_reg),
      .Tthreshold (tthreshold),
      .Depth      (depth),
      .PerCnt     (per_cnt),
      .Delay      (delay),
      .nPD        (npd),
      .WrStb      (wr_stb),
      .WrAddr     (wr_addr),
      .DB         (db)
   );

   // ---------------- scoreboard ----------------
   int         n_vec = 0;
   int         n_bad = 0;
   logic [7:0] exp_q[$];
   logic [7:0] model_addr;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One exp_q entry per WrStb cycle; a two-cycle pulse or a strobe on an
   // unmapped write finds the queue empty.
   always @(negedge clk) begin
      if (rst_n && wr_stb) begin
         if (exp_q.size() == 0) begin
            check("wr_stb_unexpected", 32'(wr_stb), 32'h0);
         end else begin
            check("wr_addr", 32'(wr_addr), 32'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Shift n bits MSB first, leaving SCK low and SDA low ready for a commit.
   task automatic send_bits(input logic [31:0] bits, input int n,
                            input logic hl);
      bus.H_L = hl;
      bus.SDA = bits[n-1];
      wait_clk(4);
      for (int i = n - 1; i >= 0; i--) begin
         bus.SCK = 1'b1;
         wait_clk(2);
         if (i > 0) bus.SDA = bits[i-1];
         else       bus.SDA = 1'b0;
         wait_clk(2);
         bus.SCK = 1'b0;
         wait_clk(4);
      end
   endtask

   task automatic commit();
      bus.SDA = 1'b1;
      wait_clk(6);
   endtask

   task automatic send_addr(input logic [7:0] a);
      send_bits(32'(a), 8, 1'b1);
      commit();
      model_addr = a;
   endtask

   task automatic send_data(input logic [7:0] d);
      if (model_addr <= 8'h0E) exp_q.push_back(model_addr);
      send_bits(32'(d), 8, 1'b0);
      commit();
      model_addr = model_addr + 8'd1;
   endtask

   // Plain bus read: value sampled after the 3rd Clk edge of the strobe.
   task automatic bus_read(input logic hl, input logic cd,
                           output logic [15:0] val);
      bus.CE  = 1'b1;
      bus.H_L = hl;
      bus.C_D = cd;
      bus.nRD = 1'b0;
      wait_clk(3);
      val = db;
      wait_clk(3);
      bus.nRD = 1'b1;
      bus.CE  = 1'b0;
      wait_clk(4);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_trigg"},  32'(trigg_mode), 32'h00);
      check({tag, "_vth"},    32'(vthreshold), 32'h00);
      check({tag, "_tth"},    32'(tthreshold), 32'h0000);
      check({tag, "_ctrl"},   32'(ctrl_reg),   32'h00);
      check({tag, "_npd"},    32'(npd),        32'h0);
      check({tag, "_depth"},  32'(depth),      32'hFFF);
      check({tag, "_percnt"}, 32'(per_cnt),    32'd150);
      check({tag, "_delay"},  32'(delay),      32'h1);
      check({tag, "_wrstb"},  32'(wr_stb),     32'h0);
      check({tag, "_wraddr"}, 32'(wr_addr),    32'h00);
      check({tag, "_db_z"},   32'(db),         32'hFFFF);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // ---------------- stimulus ----------------
   logic [15:0] rd;

   initial begin
      rst_n      = 1'b0;
      bus.SCK    = 1'b0;
      bus.SDA    = 1'b1;
      bus.CE     = 1'b0;
      bus.nRD    = 1'b1;
      bus.H_L    = 1'b0;
      bus.C_D    = 1'b0;
      dout       = 18'h0;
      start      = 1'b0;
      empty      = 1'b0;
      full       = 1'b0;
      ready      = 1'b0;
      model_addr = 8'h00;
      // Meas word of channel k, item j = {k, j, A5}; ch3 TH is overridden.
      for (int k = 0; k < NCH; k++)
         for (int j = 0; j < 3; j++)
            meas[(3*k+j)*16 +: 16] = {4'(k), 4'(j), 8'hA5};
      meas[(3*3+2)*16 +: 16] = 16'hBEEF;

      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(2);
      check_reset_state("por");
      bus_read(1'b0, 1'b0, rd);
      check("por_status", 32'(rd), 32'h0000);

      // ---- reset in the middle of a byte ----
      send_addr(8'h01);
      send_data(8'h5E);
      check("vth_5e", 32'(vthreshold), 32'h5E);
      send_bits(32'hB, 4, 1'b1);
      rst_n = 1'b0;
      wait_clk(1);
      bus.SDA = 1'b1;
      check_reset_state("midrst");
      wait_clk(2);
      rst_n = 1'b1;
      model_addr = 8'h00;
      wait_clk(2);

      // ---- address 06, auto-increment over Depth / PerCnt ----
      send_addr(8'h06);
      send_data(8'h34);
      send_data(8'h0A);
      send_data(8'h96);
      send_data(8'h00);
      check("depth_a34",   32'(depth),   32'hA34);
      check("percnt_096",  32'(per_cnt), 32'h096);

      // ---- Delay bytes then Trigg_Mode preset ----
      send_addr(8'h0A);
      send_data(8'h11);
      send_data(8'h22);
      send_data(8'h33);
      send_data(8'h44);
      check("delay_wr", 32'(delay), 32'h44332211);

      send_addr(8'h00);
      exp_q.push_back(8'h00);
      send_bits(32'h5A, 8, 1'b0);
      bus.SDA = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("trig_lat3", 32'(trigg_mode), 32'h00);
      @(posedge clk);
      #1;
      check("trig_lat4",   32'(trigg_mode), 32'h5A);
      check("wrstb_lat4",  32'(wr_stb),     32'h1);
      @(negedge clk);
      wait_clk(3);
      model_addr = 8'h01;
      check("preset_delay",  32'(delay),   32'h1);
      check("preset_depth",  32'(depth),   32'hFFF);
      check("preset_percnt", 32'(per_cnt), 32'd150);

      // ---- later writes override preset; high bits dropped ----
      send_data(8'h77);
      check("vth_77", 32'(vthreshold), 32'h77);
      send_addr(8'h08);
      send_data(8'h23);
      send_data(8'hF1);
      check("percnt_123", 32'(per_cnt), 32'h123);
      send_addr(8'h07);
      send_data(8'hF5);
      check("depth_5ff", 32'(depth), 32'h5FF);

      // ---- Tthreshold, CtrlReg, Select in one burst ----
      send_addr(8'h02);
      send_data(8'hCD);
      send_data(8'hAB);
      send_data(8'h01);
      send_data(8'h0E);
      check("tth_abcd", 32'(tthreshold), 32'hABCD);
      check("ctrl_01",  32'(ctrl_reg),   32'h01);
      check("npd_on",   32'(npd),        32'h1);

      // ---- unmapped addresses and FF->00 wrap ----
      send_addr(8'h0F);
      send_data(8'h55);
      send_addr(8'hFF);
      send_data(8'h66);
      send_data(8'h3C);
      check("wrap_trigg", 32'(trigg_mode), 32'h3C);
      check("wrap_vth",   32'(vthreshold), 32'h77);

      // ---- framing errors ----
      send_bits(32'h7F, 7, 1'b0);
      commit();
      bus_read(1'b0, 1'b0, rd);
      check("serr_7bit", 32'(rd), 32'h0040);
      check("serr_no_write", 32'(vthreshold), 32'h77);
      send_addr(8'h0E);
      send_data(8'h00);
      bus_read(1'b0, 1'b0, rd);
      check("serr_clr", 32'(rd), 32'h0000);
      send_bits(32'h1AB, 9, 1'b0);
      commit();
      bus_read(1'b0, 1'b0, rd);
      check("serr_9bit", 32'(rd), 32'h0040);
      send_addr(8'h0E);
      send_data(8'hFF);
      bus_read(1'b0, 1'b0, rd);
      check("serr_clr2", 32'(rd), 32'h0000);
      // 24 bits would alias to 8 with a wrapping counter.
      send_bits(32'h00_01_04, 24, 1'b1);
      commit();
      bus_read(1'b0, 1'b0, rd);
      check("serr_24bit", 32'(rd), 32'h0040);
      send_addr(8'h0E);
      send_data(8'h00);

      // ---- measurement readback (Select = 0x0E: ch3, TH) ----
      bus.CE  = 1'b1;
      bus.H_L = 1'b0;
      bus.C_D = 1'b1;
      bus.nRD = 1'b0;
      wait_clk(3);
      check("rd_beef", 32'(db), 32'hBEEF);
      meas[(3*3+2)*16 +: 16] = 16'h1234;
      wait_clk(3);
      check("rd_beef_hold", 32'(db), 32'hBEEF);
      bus.nRD = 1'b1;
      bus.CE  = 1'b0;
      wait_clk(4);
      bus_read(1'b0, 1'b1, rd);
      check("rd_refresh", 32'(rd), 32'h1234);

      send_addr(8'h05);
      send_data(8'h13);
      bus_read(1'b0, 1'b1, rd);
      check("rd_ch4_zero", 32'(rd), 32'h0000);
      send_addr(8'h05);
      send_data(8'h01);
      bus_read(1'b0, 1'b1, rd);
      check("rd_ch0_tl", 32'(rd), 32'h01A5);
      send_addr(8'h05);
      send_data(8'h03);
      bus_read(1'b0, 1'b1, rd);
      check("rd_item3_zero", 32'(rd), 32'h0000);

      // ---- FIFO data and status word ----
      dout = 18'h2_C3A5;
      bus_read(1'b1, 1'b0, rd);
      check("rd_dout", 32'(rd), 32'hC3A5);
      // Start(bit5) | Full(bit3) | Dout[17:16]=10 -> 0x002A
      start = 1'b1;
      full  = 1'b1;
      bus_read(1'b0, 1'b0, rd);
      check("status_start_full", 32'(rd), 32'h002A);
      // Start(bit5) | Ready(bit2) | Dout[17:16]=10 -> 0x0026
      full  = 1'b0;
      ready = 1'b1;
      bus_read(1'b0, 1'b0, rd);
      check("status_start_ready", 32'(rd), 32'h0026);

      // ---- bus released ----
      bus.CE  = 1'b0;
      bus.C_D = 1'b0;
      bus.nRD = 1'b0;
      wait_clk(3);
      check("db_z_ce0", 32'(db), 32'hFFFF);
      bus.CE  = 1'b1;
      bus.nRD = 1'b1;
      wait_clk(2);
      check("db_z_nrd1", 32'(db), 32'hFFFF);
      bus.CE = 1'b0;
      wait_clk(4);

      check("exp_q_drained", 32'(exp_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
